laser_link_ctrl: RTL and testbench

Parametrised successor to the board-level echo controller. Sits between the FTDI_Interface queue handshakes (rdq/wrq) and the LaserTransmitter/LaserReceiver handshakes. Supports four run-time modes: idle, host loopback echo, full-duplex laser bridge, and constant-pattern transmit. Adds four things the echo controller lacks: a receive-side buffer, a transmit timeout, counted drops, and saturating statistics counters.

---
 rtl/laser_link_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_laser_link_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : laser_link_ctrl
//  Description : Host-queue to laser-link controller. Supports idle, host
//                loopback echo, full-duplex laser bridge and constant-pattern
//                transmit modes, with a receive FIFO, transmit timeout,
//                counted receive drops and saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_link_ctrl #(
    parameter int                DATA_W     = 8,
    parameter int                RX_DEPTH   = 4,
    parameter int                TX_TIMEOUT = 1023,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] PATTERN    = 'h0A
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              clear_stats,
    input  logic              rdq_empty,
    input  logic [DATA_W-1:0] data_rd,
    output logic              rdreq,
    input  logic              wrq_full,
    output logic              wrreq,
    output logic [DATA_W-1:0] data_wr,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              tx_timeout,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  drop_count
);

    // FSM encoding
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ECHO     = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_TX_START = 3'd3;
    localparam logic [2:0] S_TX_WAIT  = 3'd4;

    // Run-time modes
    localparam logic [1:0] c_MODE_IDLE    = 2'd0;
    localparam logic [1:0] c_MODE_ECHO    = 2'd1;
    localparam logic [1:0] c_MODE_BRIDGE  = 2'd2;
    localparam logic [1:0] c_MODE_PATTERN = 2'd3;

    localparam int c_ADDR_W = $clog2(RX_DEPTH);
    localparam int c_FILL_W = c_ADDR_W + 1;
    localparam int c_TMR_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(TX_TIMEOUT - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(RX_DEPTH);
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic                w_rdreq_fsm;
    logic [DATA_W-1:0]   r_tx_hold;
    logic [c_TMR_W-1:0]  r_timer;

    logic [DATA_W-1:0]   r_mem [0:RX_DEPTH-1];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;

    logic [CNT_W-1:0]    r_tx_count;
    logic [CNT_W-1:0]    r_rx_count;
    logic [CNT_W-1:0]    r_drop_count;

    logic w_echo_go;
    logic w_bridge_go;
    logic w_pattern;
    logic w_tx_expire;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_pop;
    logic w_rx_offer;
    logic w_push;
    logic w_drop;
    logic w_tx_inc;

    assign w_echo_go   = en && (mode == c_MODE_ECHO) && !rdq_empty && !wrq_full;
    assign w_bridge_go = en && (mode == c_MODE_BRIDGE) && !rdq_empty;
    assign w_pattern   = en && (mode == c_MODE_PATTERN);
    // tx_done beats a coincident timeout, so expiry requires its absence
    assign w_tx_expire = (r_state == S_TX_WAIT) && !tx_done && (r_timer == c_TMR_LAST);

    assign w_fifo_empty = (r_fill == '0);
    assign w_fifo_full  = (r_fill == c_FILL_MAX);
    // Drain yields the write port to echo traffic
    assign w_pop        = !w_fifo_empty && !wrq_full && (r_state != S_ECHO);
    assign w_rx_offer   = rx_valid && en && (mode == c_MODE_BRIDGE);
    // A pop in the same cycle frees the slot a full buffer needs
    assign w_push       = w_rx_offer && (!w_fifo_full || w_pop);
    assign w_drop       = w_rx_offer && w_fifo_full && !w_pop;
    assign w_tx_inc     = tx_done && ((r_state == S_TX_WAIT) || w_pattern);

    // Next-state and read-queue pop decode; mode only matters in S_IDLE/S_ECHO
    always_comb begin
        w_next_state = r_state;
        w_rdreq_fsm  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_echo_go) begin
                    w_rdreq_fsm  = 1'b1;
                    w_next_state = S_ECHO;
                end else if (w_bridge_go) begin
                    w_rdreq_fsm  = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_ECHO: begin
                if (w_echo_go) begin
                    w_rdreq_fsm = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD:     w_next_state = S_TX_START;
            S_TX_START: w_next_state = S_TX_WAIT;
            S_TX_WAIT: begin
                if (tx_done || (r_timer == c_TMR_LAST)) begin
                    w_next_state = S_IDLE;
                end
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transmit byte capture and timeout timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_hold <= '0;
            r_timer   <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_tx_hold <= data_rd;
            end
            if (r_state == S_TX_START) begin
                r_timer <= '0;
            end else if (r_state == S_TX_WAIT) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

    // Receive buffer storage; contents are don't-care while empty
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Receive buffer pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Saturating statistics; clear wins over any increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else if (clear_stats) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_tx_inc && (r_tx_count != c_CNT_MAX)) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
            if (w_push && (r_rx_count != c_CNT_MAX)) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            if (w_drop && (r_drop_count != c_CNT_MAX)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    // Host-side outputs; held low while reset is asserted
    always_comb begin
        rdreq   = 1'b0;
        wrreq   = 1'b0;
        data_wr = '0;
        if (!reset) begin
            rdreq = w_rdreq_fsm;
            wrreq = (r_state == S_ECHO) || w_pop;
            if (r_state == S_ECHO) begin
                data_wr = data_rd;
            end else if (w_pop) begin
                data_wr = r_mem[r_rd_ptr];
            end
        end
    end

    // Laser-side outputs; PATTERN mode overrides the FSM drive
    always_comb begin
        tx_ready   = 1'b0;
        tx_data    = '0;
        tx_timeout = 1'b0;
        if (!reset) begin
            tx_timeout = w_tx_expire;
            if (w_pattern) begin
                tx_ready = 1'b1;
                tx_data  = PATTERN;
            end else begin
                tx_ready = (r_state == S_TX_START);
                if ((r_state == S_TX_START) || (r_state == S_TX_WAIT)) begin
                    tx_data = r_tx_hold;
                end
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_laser_link_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_laser_link_ctrl
//  Description : Scoreboard testbench for laser_link_ctrl with a host-queue
//                model, a queue-based receive-buffer reference and randomized
//                echo, bridge and receive traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_link_ctrl;

    localparam int          DATA_W     = 8;
    localparam int          RX_DEPTH   = 4;
    localparam int          TX_TIMEOUT = 8;
    localparam int          CNT_W      = 3;
    localparam logic [7:0]  PAT        = 8'h0A;
    localparam int          CMAX       = 7;

    logic              clock       = 1'b0;
    logic              reset       = 1'b1;
    logic              en          = 1'b0;
    logic [1:0]        mode        = 2'd0;
    logic              clear_stats = 1'b0;
    logic              rdq_empty   = 1'b1;
    logic [DATA_W-1:0] data_rd     = '0;
    logic              wrq_full    = 1'b0;
    logic              rx_valid    = 1'b0;
    logic [DATA_W-1:0] rx_data     = '0;
    logic              tx_done     = 1'b0;
    logic              rdreq;
    logic              wrreq;
    logic [DATA_W-1:0] data_wr;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_timeout;
    logic              busy;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  drop_count;

    laser_link_ctrl #(
        .DATA_W     (DATA_W),
        .RX_DEPTH   (RX_DEPTH),
        .TX_TIMEOUT (TX_TIMEOUT),
        .CNT_W      (CNT_W),
        .PATTERN    (PAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .clear_stats (clear_stats),
        .rdq_empty   (rdq_empty),
        .data_rd     (data_rd),
        .rdreq       (rdreq),
        .wrq_full    (wrq_full),
        .wrreq       (wrreq),
        .data_wr     (data_wr),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_timeout  (tx_timeout),
        .busy        (busy),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] host_q [$];
    logic [7:0] exp_wr [$];
    logic [7:0] exp_tx [$];

    int tx_total   = 0;
    int rx_total   = 0;
    int drop_total = 0;
    int occ        = 0;
    int to_seen    = 0;
    int exp_to     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no/unexpected event, expected the opposite (t=%0t)", name, $time);
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_tx_count"},   32'(tx_count),   32'(sat(tx_total)));
        check({tag, "_rx_count"},   32'(rx_count),   32'(sat(rx_total)));
        check({tag, "_drop_count"}, 32'(drop_count), 32'(sat(drop_total)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       32'(busy),       32'h0);
        check({tag, "_rdreq"},      32'(rdreq),      32'h0);
        check({tag, "_wrreq"},      32'(wrreq),      32'h0);
        check({tag, "_data_wr"},    32'(data_wr),    32'h0);
        check({tag, "_tx_ready"},   32'(tx_ready),   32'h0);
        check({tag, "_tx_data"},    32'(tx_data),    32'h0);
        check({tag, "_tx_timeout"}, 32'(tx_timeout), 32'h0);
        check({tag, "_tx_count"},   32'(tx_count),   32'h0);
        check({tag, "_rx_count"},   32'(rx_count),   32'h0);
        check({tag, "_drop_count"}, 32'(drop_count), 32'h0);
    endtask

    // Host read-queue model: a pop seen in cycle N presents data in cycle N+1
    initial begin : host_model
        bit pend;
        forever begin
            @(negedge clock);
            pend = (rdreq === 1'b1);
            @(posedge clock);
            #1;
            if (pend) begin
                if (host_q.size() > 0) data_rd = host_q.pop_front();
                else fail_event("host_pop_when_empty");
            end
            rdq_empty = (host_q.size() == 0);
        end
    end

    // Output monitor: compares every write-port and transmit presentation
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (wrreq === 1'b1) begin
                    if (exp_wr.size() == 0) fail_event("wr_unexpected");
                    else check("wr_data", 32'(data_wr), 32'(exp_wr.pop_front()));
                end else begin
                    check("data_wr_idle", 32'(data_wr), 32'h0);
                end
                if (en && mode == 2'd3) begin
                    check("pat_tx_ready", 32'(tx_ready), 32'h1);
                    check("pat_tx_data",  32'(tx_data),  32'(PAT));
                    check("pat_rdreq",    32'(rdreq),    32'h0);
                end else if (tx_ready === 1'b1) begin
                    if (exp_tx.size() == 0) fail_event("tx_unexpected");
                    else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
                if (tx_timeout === 1'b1) to_seen++;
            end
        end
    end

    task automatic wait_tx_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        fail_event("tx_ready_wait");
    endtask

    // Answer one transmit request with tx_done d cycles after tx_ready
    task automatic bridge_byte(input int d, input bit clr);
        bit ok;
        wait_tx_ready(ok);
        if (ok) begin
            repeat (d) @(posedge clock);
            #1;
            tx_done     = 1'b1;
            clear_stats = clr;
            tick();
            tx_done     = 1'b0;
            clear_stats = 1'b0;
            if (clr) begin
                tx_total = 0; rx_total = 0; drop_total = 0;
            end else begin
                tx_total++;
            end
        end
    endtask

    // One receive cycle plus the reference buffer: a queue of RX_DEPTH slots
    // that drains one byte per cycle whenever the host write queue has room
    task automatic rx_cycle(input bit rv, input bit wf, input logic [7:0] d);
        bit pop;
        rx_valid = rv;
        rx_data  = d;
        wrq_full = wf;
        pop = (occ > 0) && !wf;
        if (rv && en && mode == 2'd2) begin
            if (occ < RX_DEPTH || pop) begin
                exp_wr.push_back(d);
                rx_total++;
                occ++;
            end else begin
                drop_total++;
            end
        end
        if (pop) occ--;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        tx_total = 0; rx_total = 0; drop_total = 0;
    endtask

    initial begin : main
        int first, last, cnt, k, n;
        bit ok;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        en = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 32'h0);
        check_counts("post_reset");

        // ECHO directed: 0x11..0x14
        for (int i = 0; i < 4; i++) begin
            host_q.push_back(8'h11 + 8'(i));
            exp_wr.push_back(8'h11 + 8'(i));
        end
        tick(); tick();
        mode = 2'd1;
        first = -1; last = -1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rdreq === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("echo_rdreq_count", 32'(cnt), 32'd4);
        check("echo_rdreq_span",  32'(last - first), 32'd3);
        check("echo_busy_end",    32'(busy), 32'h0);
        check("echo_wr_drained",  32'(exp_wr.size()), 32'h0);

        // ECHO randomized with a flickering write-full
        tick();
        mode = 2'd0;
        tick();
        n = $urandom_range(3, 8);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            host_q.push_back(b);
            exp_wr.push_back(b);
        end
        tick(); tick();
        mode = 2'd1;
        for (int i = 0; i < 30; i++) begin
            wrq_full = ($urandom_range(0, 2) == 0);
            tick();
        end
        wrq_full = 1'b0;
        repeat (15) tick();
        check("echo_rand_wr_drained", 32'(exp_wr.size()), 32'h0);
        check("echo_rand_host_empty", 32'(host_q.size()), 32'h0);
        mode = 2'd0;
        tick(); tick();

        // BRIDGE directed: tx_done coincides with the timeout boundary
        host_q.push_back(8'hA5);
        exp_tx.push_back(8'hA5);
        tick(); tick();
        mode = 2'd2;
        bridge_byte(TX_TIMEOUT, 1'b0);
        tick();
        check_counts("bridge_dir");
        check("bridge_dir_tx_drained", 32'(exp_tx.size()), 32'h0);
        check("bridge_dir_no_timeout", 32'(to_seen), 32'(exp_to));

        // BRIDGE randomized response delays
        mode = 2'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            host_q.push_back(b);
            exp_tx.push_back(b);
        end
        tick(); tick();
        mode = 2'd2;
        for (int i = 0; i < 4; i++) bridge_byte($urandom_range(1, TX_TIMEOUT - 1), 1'b0);
        tick();
        check_counts("bridge_rand");
        check("bridge_rand_host_empty", 32'(host_q.size()), 32'h0);

        // Timeout: tx_done never arrives
        host_q.push_back(8'h3C);
        exp_tx.push_back(8'h3C);
        wait_tx_ready(ok);
        k = 0;
        if (ok) begin
            for (int i = 1; i <= 20; i++) begin
                @(negedge clock);
                if (tx_timeout === 1'b1) begin
                    k = i;
                    break;
                end
            end
            exp_to++;
            check("timeout_latency", 32'(k), 32'(TX_TIMEOUT));
            @(negedge clock);
            check("timeout_one_cycle", 32'(tx_timeout), 32'h0);
            check("timeout_busy_idle", 32'(busy), 32'h0);
        end
        tick();
        check_counts("timeout");

        // PATTERN: host byte present but never fetched
        mode = 2'd0;
        host_q.push_back(8'h77);
        tick(); tick();
        mode = 2'd3;
        repeat (3) begin
            tick(); tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            tx_total++;
        end
        tick();
        check_counts("pattern_sat");
        mode = 2'd0;
        tick();
        check("pattern_host_untouched", 32'(host_q.size()), 32'h1);
        host_q.delete();
        tick(); tick();

        // Clear statistics
        clear();
        check_counts("cleared");

        // Receive directed: 6 bytes into a 4-deep buffer while write-full
        mode = 2'd2;
        tick();
        for (int i = 0; i < 6; i++) rx_cycle(1'b1, 1'b1, 8'h40 + 8'(i));
        check("rx_dir_rx_count",   32'(rx_count),   32'd4);
        check("rx_dir_drop_count", 32'(drop_count), 32'd2);
        for (int i = 0; i < 8; i++) rx_cycle(1'b0, 1'b0, 8'h00);
        check("rx_dir_drained", 32'(exp_wr.size()), 32'h0);
        check_counts("rx_dir");

        // Receive offered outside BRIDGE is ignored
        mode = 2'd0;
        tick();
        for (int i = 0; i < 3; i++) rx_cycle(1'b1, 1'b0, 8'hE0 + 8'(i));
        repeat (3) tick();
        check_counts("rx_idle_mode");

        // Receive randomized traffic against the buffer reference
        mode = 2'd2;
        tick();
        for (int i = 0; i < 80; i++)
            rx_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), 8'($urandom));
        for (int i = 0; i < 10; i++) rx_cycle(1'b0, 1'b0, 8'h00);
        check("rx_rand_drained", 32'(exp_wr.size()), 32'h0);
        check_counts("rx_rand");

        // Reset during S_TX_WAIT
        host_q.push_back(8'h5A);
        exp_tx.push_back(8'h5A);
        wait_tx_ready(ok);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        tx_total = 0; rx_total = 0; drop_total = 0; occ = 0;
        tick();
        reset = 1'b0;
        tick();
        check("midreset_busy_after", 32'(busy), 32'h0);

        // clear_stats coincident with tx_done
        host_q.push_back(8'h99);
        exp_tx.push_back(8'h99);
        bridge_byte(3, 1'b1);
        tick();
        check("clear_vs_done_tx_count", 32'(tx_count), 32'h0);
        check_counts("clear_vs_done");

        mode = 2'd0;
        repeat (4) tick();
        check("final_wr_empty", 32'(exp_wr.size()), 32'h0);
        check("final_tx_empty", 32'(exp_tx.size()), 32'h0);
        check("timeout_pulse_total", 32'(to_seen), 32'(exp_to));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
